// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Hardwired control FSM that steps a two-bus register datapath through
//   fetch (T0..T2), decode (T3) and execute (T4..T6). It supports 3-register
//   ALU ops (Ra <- Rb op Rc) and 2-register mul/div (HI:LO <- Rb op Rc).
//
// Parameters
//   MEM_WAIT  extra T1 cycles (Read held high) before IR is loaded, 0..15
//   OP_W      opcode width, opcode taken from IR[31 -: OP_W]
//
// Ports
//   Clock, Reset         clock, synchronous active-high reset
//   Stop                 level: finish current instruction, then halt
//   Step                 single-step pulse (only with SINGLE_STEP_EN)
//   IR                   instruction register contents
//   PCout..IRin          fetch strobes
//   Yin..HIin            execute strobes
//   Rout_sel, Rin_sel    one-hot register bus-out select / write enable
//   operation            ALU op code, valid in T4 only
//   Run                  1 while not halted
//   Illegal              sticky flag for unsupported opcode
//
// Build option
//   SINGLE_STEP_EN  when defined, the FSM parks in PAUSE after each
//                   instruction until Step (resume) or Stop (halt).
module alu_op_sequencer #(
  parameter int MEM_WAIT = 0,
  parameter int OP_W     = 5
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Stop,
  input  logic            Step,
  input  logic [31:0]     IR,
  output logic            PCout,
  output logic            MARin,
  output logic            IncPC,
  output logic            PCin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zlowin,
  output logic            Zhighin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            LOin,
  output logic            HIin,
  output logic [15:0]     Rout_sel,
  output logic [15:0]     Rin_sel,
  output logic [OP_W-1:0] operation,
  output logic            Run,
  output logic            Illegal
);

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(5'b00100);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(5'b00101);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(5'b00110);
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(5'b01111);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(5'b10000);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
`ifdef SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

`ifdef SINGLE_STEP_EN
  localparam state_t S_RESUME = S_PAUSE;
`else
  localparam state_t S_RESUME = S_T0;
`endif

  state_t          state;
  logic [3:0]      wait_cnt;
  logic [OP_W-1:0] op_q;
  logic [3:0]      ra_q;
  logic [3:0]      rc_q;

  logic [OP_W-1:0] op_in;
  logic [3:0]      ra_in;
  logic [3:0]      rb_in;
  logic [3:0]      rc_in;

  assign op_in = IR[31 -: OP_W];
  assign ra_in = IR[26:23];
  assign rb_in = IR[22:19];
  assign rc_in = IR[18:15];

  // Low IR bits carry no control information; Step is inert without PAUSE.
  logic ir_unused;
`ifdef SINGLE_STEP_EN
  assign ir_unused = ^IR[14:0];
`else
  assign ir_unused = ^{IR[14:0], Step};
`endif

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || is_muldiv(op);
  endfunction

  function automatic logic [15:0] onehot(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

  // Control state. Stop is only looked at in the last execute state
  // (T5 for ALU ops, T6 for mul/div) and, with single-step, in PAUSE.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_T0;
      wait_cnt <= 4'd0;
      Illegal  <= 1'b0;
      Run      <= 1'b1;
    end else begin
      case (state)
        S_T0: state <= S_T1;
        S_T1: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= 4'd0;
            state    <= S_T2;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_T2: state <= S_T3;
        S_T3: begin
          if (is_legal(op_in)) begin
            state <= S_T4;
          end else begin
            Illegal <= 1'b1;
            Run     <= 1'b0;
            state   <= S_HALT;
          end
        end
        S_T4: state <= S_T5;
        S_T5: begin
          if (is_muldiv(op_q)) begin
            state <= S_T6;
          end else if (Stop) begin
            Run   <= 1'b0;
            state <= S_HALT;
          end else begin
            state <= S_RESUME;
          end
        end
        S_T6: begin
          if (Stop) begin
            Run   <= 1'b0;
            state <= S_HALT;
          end else begin
            state <= S_RESUME;
          end
        end
`ifdef SINGLE_STEP_EN
        S_PAUSE: begin
          if (Stop) begin
            Run   <= 1'b0;
            state <= S_HALT;
          end else if (Step) begin
            state <= S_T0;
          end
        end
`endif
        default: state <= S_HALT;
      endcase
    end
  end

  // Instruction fields are captured at the end of T3 so execute states do
  // not depend on IR staying stable afterwards.
  always_ff @(posedge Clock) begin
    if (state == S_T3) begin
      op_q <= op_in;
      ra_q <= ra_in;
      rc_q <= rc_in;
    end
  end

  // Strobes are a pure decode of state; Reset forces them low in the same
  // cycle so an aborted instruction never writes a register.
  always_comb begin
    PCout     = 1'b0;
    MARin     = 1'b0;
    IncPC     = 1'b0;
    PCin      = 1'b0;
    Read      = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zlowin    = 1'b0;
    Zhighin   = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    LOin      = 1'b0;
    HIin      = 1'b0;
    Rout_sel  = 16'h0000;
    Rin_sel   = 16'h0000;
    operation = '0;
    if (!Reset) begin
      case (state)
        S_T0: begin
          PCout  = 1'b1;
          MARin  = 1'b1;
          IncPC  = 1'b1;
          Zlowin = 1'b1;
        end
        S_T1: begin
          Read  = 1'b1;
          MDRin = 1'b1;
          // PC+1 is written back only once, however long memory stalls.
          if (wait_cnt == 4'd0) begin
            PCin    = 1'b1;
            Zlowout = 1'b1;
          end
        end
        S_T2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        S_T3: begin
          if (is_legal(op_in)) begin
            Yin      = 1'b1;
            Rout_sel = onehot(rb_in);
          end
        end
        S_T4: begin
          Rout_sel  = onehot(rc_q);
          operation = op_q;
          Zlowin    = 1'b1;
          Zhighin   = is_muldiv(op_q);
        end
        S_T5: begin
          Zlowout = 1'b1;
          if (is_muldiv(op_q)) begin
            LOin = 1'b1;
          end else begin
            Rin_sel = onehot(ra_q);
          end
        end
        S_T6: begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
